// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Identity of the requester that owns the write port in a given cycle.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_MEM  = 2'd1,
    REQ_ALU  = 2'd2
  } req_id_e;

  // Hard-wired zero register: writes to it are consumed but dropped.
  localparam int unsigned X0 = 0;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive contested cycles the ALU has lost.
module wb_starve_ctr #(
  parameter int CNT_W = 2,
  parameter int LIMIT = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             atLimit
);

  assign atLimit = (cnt == CNT_W'(LIMIT));

  // Clear wins over increment; increment stops at the limit.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !atLimit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and load
// unit writeback paths and registers the winning write for one cycle.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluRd,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  output logic              regWen,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic [1:0]        starveCnt
);

  logic    aluX0, memX0, aluWr, memWr, contested;
  logic    atLimit, starveInc, starveClr;
  req_id_e grant;

  logic              wen_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic [DATA_W-1:0] data_p1;

  // x0 requests never compete; only real writes contend for the port.
  assign aluX0     = aluValid && (aluRd == ADDR_W'(X0));
  assign memX0     = memValid && (memRd == ADDR_W'(X0));
  assign aluWr     = aluValid && !aluX0;
  assign memWr     = memValid && !memX0;
  assign contested = aluWr && memWr;

  // Fixed priority to the older load, overridden once the ALU has starved.
  always_comb begin
    aluReady = 1'b0;
    memReady = 1'b0;
    grant    = REQ_NONE;
    if (Rst) begin
      if (aluX0) aluReady = 1'b1;
      if (memX0) memReady = 1'b1;
      if (aluWr && (!memWr || atLimit)) begin
        aluReady = 1'b1;
        grant    = REQ_ALU;
      end else if (memWr) begin
        memReady = 1'b1;
        grant    = REQ_MEM;
      end
    end
  end

  assign starveInc = contested && (grant == REQ_MEM);
  assign starveClr = (grant == REQ_ALU);

  wb_starve_ctr #(
    .CNT_W (2),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .Clk     (Clk),
    .Rst     (Rst),
    .inc     (starveInc),
    .clr     (starveClr),
    .cnt     (starveCnt),
    .atLimit (atLimit)
  );

  // Stage p0 -> p1: register the granted write; index/data hold when idle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wen_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      wen_p1 <= (grant != REQ_NONE);
      if (grant == REQ_ALU) begin
        rd_p1   <= aluRd;
        data_p1 <= aluData;
      end else if (grant == REQ_MEM) begin
        rd_p1   <= memRd;
        data_p1 <= memData;
      end
    end
  end

  assign regWen    = wen_p1;
  assign writeReg  = rd_p1;
  assign writeData = data_p1;

endmodule
